// File: rtl/code_packer_pkg.sv
// Shared definitions for the code packer: FSM encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package code_packer_pkg;

  // Default output word width and maximum code length, in bits.
  localparam int BITWIDTH_DEF = 64;
  localparam int CODE_MAX_DEF = 32;

  // Fixed port widths of the code length and the written-word counter.
  localparam int LEN_W  = 6;
  localparam int WCNT_W = 16;

  // Packer control states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/code_packer_if.sv
// Code-in / word-out bus of the code packer.
// Latency: n/a (bundle of wires); slave = packer side, master = producer/FIFO side.
// Backpressure: code path via valid_i/ready_o, word path via fifo_wr_o/fifo_full_i.
// Signals: code_i/len_i/valid_i/ready_o (code handshake), flush_i, fifo_data_o/fifo_wr_o/
//          fifo_full_i (FIFO write port), flush_done_o, word_cnt_o, err_o (status).
interface code_packer_if #(
  parameter int BITWIDTH = code_packer_pkg::BITWIDTH_DEF,
  parameter int CODE_MAX = code_packer_pkg::CODE_MAX_DEF
);
  logic [CODE_MAX-1:0]                   code_i;
  logic [code_packer_pkg::LEN_W-1:0]     len_i;
  logic                                  valid_i;
  logic                                  ready_o;
  logic                                  flush_i;
  logic [BITWIDTH-1:0]                   fifo_data_o;
  logic                                  fifo_wr_o;
  logic                                  fifo_full_i;
  logic                                  flush_done_o;
  logic [code_packer_pkg::WCNT_W-1:0]    word_cnt_o;
  logic                                  err_o;

  modport slave (
    input  code_i, len_i, valid_i, flush_i, fifo_full_i,
    output ready_o, fifo_data_o, fifo_wr_o, flush_done_o, word_cnt_o, err_o
  );

  modport master (
    output code_i, len_i, valid_i, flush_i, fifo_full_i,
    input  ready_o, fifo_data_o, fifo_wr_o, flush_done_o, word_cnt_o, err_o
  );
endinterface

// File: rtl/code_packer_pack_shifter.sv
// Masks a code to its length and merges it into the accumulator at the fill count.
// Latency: combinational.
// Backpressure: none; ports acc_i/code_i/len_i/cnt_i in, merged_o/ovf_o/cnt_o/full_o out.
module pack_shifter
  import code_packer_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEF,
  parameter int CODE_MAX = CODE_MAX_DEF
) (
  input  logic [BITWIDTH-1:0]         acc_i,
  input  logic [CODE_MAX-1:0]         code_i,
  input  logic [LEN_W-1:0]            len_i,
  input  logic [$clog2(BITWIDTH)-1:0] cnt_i,
  output logic [BITWIDTH-1:0]         merged_o,
  output logic [BITWIDTH-1:0]         ovf_o,
  output logic [$clog2(BITWIDTH)-1:0] cnt_o,
  output logic                        full_o
);
  localparam int CW = $clog2(BITWIDTH);

  logic [CODE_MAX-1:0]   mask;
  logic [2*BITWIDTH-1:0] wide;
  int                    sum;

  always_comb begin
    mask = '0;
    for (int i = 0; i < CODE_MAX; i++) begin
      mask[i] = (int'(len_i) > i);
    end
    // Double-width shift: the upper half holds the bits that spill past the word.
    wide = {{BITWIDTH{1'b0}}, acc_i}
         | ({{(2*BITWIDTH-CODE_MAX){1'b0}}, code_i & mask} << cnt_i);
    sum      = int'(cnt_i) + int'(len_i);
    full_o   = (sum >= BITWIDTH);
    cnt_o    = full_o ? CW'(sum - BITWIDTH) : CW'(sum);
    merged_o = wide[BITWIDTH-1:0];
    ovf_o    = wide[2*BITWIDTH-1:BITWIDTH];
  end
endmodule

// File: rtl/code_packer.sv
// Packs variable-length codes LSB-first into BITWIDTH-bit words for a downstream FIFO.
// Latency: a word appears on fifo_wr_o one cycle after the code that completes it is accepted.
// Backpressure: one output slot; ready_o drops while the slot is held by fifo_full_i or a flush runs.
// Ports: clk, rst_n (async active-low), bus (code_packer_if.slave).
module code_packer
  import code_packer_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEF,
  parameter int CODE_MAX = CODE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  code_packer_if.slave  bus
);
  localparam int CW = $clog2(BITWIDTH);

  state_e              state_q, state_d;
  logic [BITWIDTH-1:0] acc_q, acc_d;
  logic [BITWIDTH-1:0] out_q, out_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

  logic [BITWIDTH-1:0] sh_merged, sh_ovf;
  logic [CW-1:0]       sh_cnt;
  logic                sh_full;

  logic slot_free, wr_done, ready, accept, len_bad, len_use;

  pack_shifter #(
    .BITWIDTH (BITWIDTH),
    .CODE_MAX (CODE_MAX)
  ) u_shift (
    .acc_i    (acc_q),
    .code_i   (bus.code_i),
    .len_i    (bus.len_i),
    .cnt_i    (cnt_q),
    .merged_o (sh_merged),
    .ovf_o    (sh_ovf),
    .cnt_o    (sh_cnt),
    .full_o   (sh_full)
  );

  // A slot that drains this cycle counts as free, so a full word can stream every cycle.
  assign slot_free = ~wr_q | ~bus.fifo_full_i;
  assign wr_done   = wr_q & ~bus.fifo_full_i;
  assign ready     = (state_q == RUN) & slot_free;
  assign accept    = bus.valid_i & ready;
  assign len_bad   = int'(bus.len_i) > CODE_MAX;
  assign len_use   = accept & ~len_bad & (bus.len_i != '0);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    wr_d    = wr_q & bus.fifo_full_i;
    done_d  = 1'b0;
    err_d   = err_q | (accept & len_bad);
    wcnt_d  = wcnt_q + {{(WCNT_W-1){1'b0}}, wr_done};

    case (state_q)
      RUN: begin
        if (len_use) begin
          cnt_d = sh_cnt;
          if (sh_full) begin
            out_d = sh_merged;
            wr_d  = 1'b1;
            acc_d = sh_ovf;
          end else begin
            acc_d = sh_merged;
          end
        end
        if (bus.flush_i & ready) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = DRAIN;
        end else if (slot_free) begin
          // Bits above cnt are always zero, so the accumulator is already padded.
          out_d   = acc_q;
          wr_d    = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!wr_q) begin
          done_d  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign bus.ready_o      = ready;
  assign bus.fifo_data_o  = out_q;
  assign bus.fifo_wr_o    = wr_q;
  assign bus.flush_done_o = done_q;
  assign bus.word_cnt_o   = wcnt_q;
  assign bus.err_o        = err_q;
endmodule

// File: tb/tb_code_packer.sv
// Testbench for code_packer: bit-stream reference model plus directed and random stimulus.
// Latency: inputs change 1 time unit after posedge, outputs are compared at negedge.
// Backpressure: fifo_full_i driven directly by the bench, both held and randomized.
module tb_code_packer;
  localparam int BW = 64;
  localparam int CM = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  code_packer_if #(.BITWIDTH(BW), .CODE_MAX(CM)) bus ();

  code_packer #(.BITWIDTH(BW), .CODE_MAX(CM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int writes_total = 0;
  int done_seen = 0;
  int acc_cyc = 0;
  int done_cyc = 0;

  // Reference model: the accepted code bits as a plain LSB-first stream, and the
  // words that stream must produce, in order.
  bit          bitq[$];
  logic [63:0] exp_words[$];
  logic [15:0] wcount = '0;
  bit          err_m, flush_pend, exp_wr_next, prev_stall, last_accept, last_flush_acc;
  logic [63:0] prev_data, last_word;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] pop_word();
    logic [63:0] w = '0;
    for (int i = 0; i < BW; i++) begin
      if (bitq.size() > 0) w[i] = bitq.pop_front();
    end
    return w;
  endfunction

  task automatic monitor();
    bit xfer, acc, fl;
    cyc++;
    if (!rst_n) begin
      chk("rst_fifo_wr", 64'(bus.fifo_wr_o), 64'd0);
      chk("rst_fifo_data", bus.fifo_data_o, 64'd0);
      chk("rst_word_cnt", 64'(bus.word_cnt_o), 64'd0);
      chk("rst_err", 64'(bus.err_o), 64'd0);
      chk("rst_flush_done", 64'(bus.flush_done_o), 64'd0);
      chk("rst_ready", 64'(bus.ready_o), 64'd1);
      bitq.delete();
      exp_words.delete();
      wcount = '0;
      err_m = 1'b0;
      flush_pend = 1'b0;
      exp_wr_next = 1'b0;
      prev_stall = 1'b0;
      last_accept = 1'b0;
      last_flush_acc = 1'b0;
      return;
    end
    xfer = bus.fifo_wr_o & ~bus.fifo_full_i;
    acc  = bus.valid_i & bus.ready_o;
    fl   = bus.flush_i & bus.ready_o;

    chk("word_cnt", 64'(bus.word_cnt_o), 64'(wcount));
    chk("err", 64'(bus.err_o), 64'(err_m));
    if (exp_wr_next) chk("wr_latency", 64'(bus.fifo_wr_o), 64'd1);
    exp_wr_next = 1'b0;
    if (prev_stall) begin
      chk("stall_wr_hold", 64'(bus.fifo_wr_o), 64'd1);
      chk("stall_data_hold", bus.fifo_data_o, prev_data);
    end
    if (bus.fifo_wr_o) begin
      chk("wr_expected", 64'(exp_words.size() != 0), 64'd1);
      if (exp_words.size() != 0) chk("wr_data", bus.fifo_data_o, exp_words[0]);
    end
    if (bus.flush_done_o) begin
      chk("done_while_flushing", 64'(flush_pend), 64'd1);
      chk("done_words_left", 64'(exp_words.size()), 64'd0);
      flush_pend = 1'b0;
      done_seen++;
      done_cyc = cyc;
    end
    if (flush_pend) chk("ready_in_flush", 64'(bus.ready_o), 64'd0);
    else chk("ready", 64'(bus.ready_o), 64'(!(bus.fifo_wr_o & bus.fifo_full_i)));

    prev_stall = bus.fifo_wr_o & bus.fifo_full_i;
    prev_data  = bus.fifo_data_o;
    if (xfer) begin
      if (exp_words.size() != 0) void'(exp_words.pop_front());
      wcount++;
      writes_total++;
      last_word = bus.fifo_data_o;
    end
    if (acc) begin
      if (int'(bus.len_i) > CM) begin
        err_m = 1'b1;
      end else begin
        for (int i = 0; i < int'(bus.len_i); i++) bitq.push_back(bus.code_i[i]);
        if (bitq.size() >= BW) begin
          exp_words.push_back(pop_word());
          exp_wr_next = 1'b1;
        end
      end
    end
    if (fl) begin
      if (bitq.size() > 0) exp_words.push_back(pop_word());
      flush_pend = 1'b1;
      acc_cyc = cyc;
    end
    last_accept = acc;
    last_flush_acc = fl;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [31:0] code, input int len, input bit fl);
    int n = 0;
    bus.code_i  = code;
    bus.len_i   = 6'(len);
    bus.valid_i = 1'b1;
    bus.flush_i = fl;
    do begin
      step();
      n++;
    end while (!last_accept && n < 200);
    chk("send_accepted", 64'(last_accept), 64'd1);
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
  endtask

  task automatic wait_done();
    int start = done_seen;
    int n = 0;
    while (done_seen == start && n < 200) begin
      step();
      n++;
    end
    chk("flush_done_seen", 64'(done_seen != start), 64'd1);
  endtask

  task automatic do_flush();
    int n = 0;
    bus.flush_i = 1'b1;
    do begin
      step();
      n++;
    end while (!last_flush_acc && n < 200);
    chk("flush_accepted", 64'(last_flush_acc), 64'd1);
    bus.flush_i = 1'b0;
    wait_done();
  endtask

  initial begin
    int w0;
    int d0;
    bus.code_i = '0;
    bus.len_i = '0;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.fifo_full_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) step();
    rst_n = 1'b1;
    idle(2);

    // Eight byte codes fill exactly one word; a following flush has nothing to pad.
    w0 = writes_total;
    for (int i = 1; i <= 8; i++) send(32'(i), 8, 1'b0);
    idle(2);
    chk("t_eight_bytes_word", last_word, 64'h0807060504030201);
    chk("t_eight_bytes_writes", 64'(writes_total - w0), 64'd1);
    chk("t_eight_bytes_wcnt", 64'(bus.word_cnt_o), 64'd1);
    do_flush();
    chk("t_empty_flush_no_write", 64'(writes_total - w0), 64'd1);
    chk("t_empty_flush_latency", 64'(done_cyc - acc_cyc), 64'd3);

    // Fill to 60 bits, then a byte straddles the word boundary.
    w0 = writes_total;
    send(32'h0000_1234, 30, 1'b0);
    send(32'h0000_0056, 30, 1'b0);
    send(32'h0000_00FF, 8, 1'b0);
    idle(1);
    chk("t_straddle_word", last_word, 64'hF000_0015_8000_1234);
    do_flush();
    chk("t_straddle_remainder", last_word, 64'h0000_0000_0000_000F);
    chk("t_straddle_writes", 64'(writes_total - w0), 64'd2);

    // Hold the downstream FIFO full with a word pending.
    w0 = writes_total;
    for (int i = 1; i <= 8; i++) send(32'(i * 17), 8, 1'b0);
    bus.fifo_full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t_full_wr_hold", 64'(bus.fifo_wr_o), 64'd1);
      chk("t_full_data_hold", bus.fifo_data_o, 64'h8877665544332211);
      chk("t_full_ready_low", 64'(bus.ready_o), 64'd0);
    end
    bus.fifo_full_i = 1'b0;
    #1;
    chk("t_release_ready", 64'(bus.ready_o), 64'd1);
    chk("t_release_wr", 64'(bus.fifo_wr_o), 64'd1);
    step();
    chk("t_release_writes", 64'(writes_total - w0), 64'd1);
    chk("t_release_word", last_word, 64'h8877665544332211);

    // Short code then flush: padded word and a single done pulse.
    d0 = done_seen;
    send(32'h5, 3, 1'b0);
    do_flush();
    idle(5);
    chk("t_pad_word", last_word, 64'h0000_0000_0000_0005);
    chk("t_pad_done_once", 64'(done_seen - d0), 64'd1);
    chk("t_pad_ready_after", 64'(bus.ready_o), 64'd1);

    // Over-long code is dropped and latches the error flag.
    send(32'hAB, 8, 1'b0);
    send(32'hFFFF_FFFF, 40, 1'b0);
    chk("t_badlen_err", 64'(bus.err_o), 64'd1);
    send(32'hCD, 8, 1'b0);
    do_flush();
    chk("t_badlen_dropped", last_word, 64'h0000_0000_0000_CDAB);
    idle(3);
    chk("t_badlen_err_sticky", 64'(bus.err_o), 64'd1);

    // Reset with a stalled word and a partial word: both are discarded.
    for (int i = 0; i < 7; i++) send(32'h99, 8, 1'b0);
    send(32'h7777, 16, 1'b0);
    bus.fifo_full_i = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    chk("t_midrst_wr", 64'(bus.fifo_wr_o), 64'd0);
    chk("t_midrst_data", bus.fifo_data_o, 64'd0);
    chk("t_midrst_ready", 64'(bus.ready_o), 64'd1);
    step();
    step();
    rst_n = 1'b1;
    bus.fifo_full_i = 1'b0;
    w0 = writes_total;
    idle(10);
    chk("t_midrst_no_write", 64'(writes_total - w0), 64'd0);
    chk("t_midrst_wcnt", 64'(bus.word_cnt_o), 64'd0);
    chk("t_midrst_err", 64'(bus.err_o), 64'd0);
    do_flush();
    chk("t_midrst_flush_empty", 64'(writes_total - w0), 64'd0);

    // Randomized traffic with random backpressure and occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      bus.valid_i = ($urandom_range(0, 3) != 0);
      bus.code_i = $urandom;
      if (r < 5) bus.len_i = 6'd0;
      else if (r < 8) bus.len_i = 6'($urandom_range(33, 40));
      else bus.len_i = 6'($urandom_range(1, 32));
      bus.flush_i = ($urandom_range(0, 49) == 0);
      bus.fifo_full_i = ($urandom_range(0, 3) == 0);
      step();
    end
    bus.valid_i = 1'b0;
    bus.fifo_full_i = 1'b0;
    idle(2);
    do_flush();
    idle(3);
    chk("end_words_left", 64'(exp_words.size()), 64'd0);
    chk("end_bits_left", 64'(bitq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
